// File: rtl/cp0_timer_irq_unit.sv
// CP0 coprocessor for the MIPS pipeline, MEM stage.
// Holds SR, Cause, EPC, PrID, BadVAddr and the Count/Compare timer. External
// interrupt lines are level-sampled or rising-edge latched, per line, and the
// unit raises one combined interrupt/exception request for the flush/redirect
// logic.

module cp0_timer_irq_unit #(
    parameter int          NUM_HWINT  = 6,
    parameter logic [5:0]  EDGE_MASK  = 6'b000000,
    parameter int          TIMER_LINE = 5,
    parameter logic [31:0] PRID       = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           rd_addr,
    input  logic [4:0]           wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 we,
    input  logic [31:0]          pc,
    input  logic                 bd,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          bad_vaddr_in,
    input  logic                 eret,
    input  logic [NUM_HWINT-1:0] hw_int,
    output logic                 int_exc_req,
    output logic [31:0]          epc,
    output logic [31:0]          rd_data,
    output logic                 timer_irq
);

    // Lines that physically exist; IP/IM bits outside this set are held at 0.
    localparam logic [6:0] LINE_MASK_W = (7'd1 << NUM_HWINT) - 7'd1;
    localparam logic [5:0] LINE_MASK   = LINE_MASK_W[5:0];
    localparam logic [5:0] TIMER_BIT   = 6'd1 << TIMER_LINE;
    localparam logic [5:0] EDGE_LINES  = EDGE_MASK & LINE_MASK;

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_SR       = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;

    logic [5:0]  imQ, imD;
    logic        exlQ, exlD;
    logic        ieQ, ieD;
    logic        bdQ, bdD;
    logic [4:0]  excCodeQ, excCodeD;
    logic [31:0] epcQ, epcD;
    logic [31:0] badVAddrQ, badVAddrD;
    logic [31:0] countQ, countD;
    logic [31:0] compareQ, compareD;
    logic        pendingQ, pendingD;
    logic [5:0]  levelQ, levelD;
    logic [5:0]  edgeLatQ, edgeLatD;
    logic [5:0]  hwPrevQ, hwPrevD;

    logic [5:0]  hwPad;
    logic [5:0]  ipEff;
    logic        intReq;
    logic        excReq;
    logic        wrOk;
    logic        wrSr, wrCause, wrEpc, wrCount, wrCompare;
    logic [5:0]  causeClear;

    // Widen the external lines to the full six-bit IP field and form the pending view.
    always_comb begin
        hwPad                  = '0;
        hwPad[NUM_HWINT-1:0]   = hw_int;
        ipEff = (((EDGE_LINES & edgeLatQ) | (~EDGE_LINES & levelQ))
                 | (pendingQ ? TIMER_BIT : 6'd0)) & LINE_MASK;
    end

    // Request generation; a flushed mtc0 must not touch any register.
    always_comb begin
        intReq      = ieQ & ~exlQ & (|(imQ & ipEff));
        excReq      = (exc_code != 5'd0) & ~exlQ;
        int_exc_req = intReq | excReq;
        wrOk        = we & ~int_exc_req;
        wrSr        = wrOk & (wr_addr == ADDR_SR);
        wrCause     = wrOk & (wr_addr == ADDR_CAUSE);
        wrEpc       = wrOk & (wr_addr == ADDR_EPC);
        wrCount     = wrOk & (wr_addr == ADDR_COUNT);
        wrCompare   = wrOk & (wr_addr == ADDR_COMPARE);
    end

    // Interrupt line sampling; a new rising edge beats a software clear in the same cycle.
    always_comb begin
        causeClear = wrCause ? ~wr_data[15:10] : 6'd0;
        levelD     = hwPad & LINE_MASK;
        hwPrevD    = hwPad;
        edgeLatD   = ((edgeLatQ & ~causeClear) | (hwPad & ~hwPrevQ)) & EDGE_LINES;
    end

    // Free-running Count and the Compare match flag; a Compare write always clears the flag.
    always_comb begin
        countD   = wrCount ? wr_data : countQ + 32'd1;
        compareD = wrCompare ? wr_data : compareQ;
        if (wrCompare) begin
            pendingD = 1'b0;
        end else begin
            pendingD = pendingQ | (countQ == compareQ);
        end
    end

    // Status/Cause/EPC next state: taking a request overrides software writes and eret.
    always_comb begin
        imD       = imQ;
        exlD      = exlQ;
        ieD       = ieQ;
        bdD       = bdQ;
        excCodeD  = excCodeQ;
        epcD      = epcQ;
        badVAddrD = badVAddrQ;
        if (int_exc_req) begin
            exlD     = 1'b1;
            bdD      = bd;
            epcD     = bd ? (pc - 32'd4) : pc;
            excCodeD = intReq ? 5'd0 : exc_code;
            if (!intReq && ((exc_code == 5'd4) || (exc_code == 5'd5))) begin
                badVAddrD = bad_vaddr_in;
            end
        end else begin
            if (wrSr) begin
                imD  = wr_data[15:10] & LINE_MASK;
                exlD = wr_data[1];
                ieD  = wr_data[0];
            end
            if (wrEpc) begin
                epcD = wr_data;
            end
            if (eret) begin
                exlD = 1'b0;
            end
        end
    end

    // State registers with synchronous reset to the all-clear state.
    always_ff @(posedge clk) begin
        if (reset) begin
            imQ       <= '0;
            exlQ      <= 1'b0;
            ieQ       <= 1'b0;
            bdQ       <= 1'b0;
            excCodeQ  <= '0;
            epcQ      <= '0;
            badVAddrQ <= '0;
            countQ    <= '0;
            compareQ  <= '0;
            pendingQ  <= 1'b0;
            levelQ    <= '0;
            edgeLatQ  <= '0;
            hwPrevQ   <= '0;
        end else begin
            imQ       <= imD;
            exlQ      <= exlD;
            ieQ       <= ieD;
            bdQ       <= bdD;
            excCodeQ  <= excCodeD;
            epcQ      <= epcD;
            badVAddrQ <= badVAddrD;
            countQ    <= countD;
            compareQ  <= compareD;
            pendingQ  <= pendingD;
            levelQ    <= levelD;
            edgeLatQ  <= edgeLatD;
            hwPrevQ   <= hwPrevD;
        end
    end

    // mfc0 read mux; unmapped numbers read as zero.
    always_comb begin
        rd_data = 32'd0;
        case (rd_addr)
            ADDR_BADVADDR: rd_data = badVAddrQ;
            ADDR_COUNT:    rd_data = countQ;
            ADDR_COMPARE:  rd_data = compareQ;
            ADDR_SR:       rd_data = {16'd0, imQ, 8'd0, exlQ, ieQ};
            ADDR_CAUSE:    rd_data = {bdQ, 15'd0, ipEff, 3'd0, excCodeQ, 2'd0};
            ADDR_EPC:      rd_data = epcQ;
            ADDR_PRID:     rd_data = PRID;
            default:       rd_data = 32'd0;
        endcase
    end

    assign epc       = epcQ;
    assign timer_irq = pendingQ;

endmodule

// File: tb/tb_cp0_timer_irq_unit.sv
// Self-checking bench for cp0_timer_irq_unit.
// Each scenario pushes its expected observations onto a scoreboard queue as it
// drives stimulus, then drains the queue against the DUT outputs.

module tb_cp0_timer_irq_unit;

    localparam logic [31:0] TB_PRID = 32'h0001_9300;

    localparam int K_RD    = 0;
    localparam int K_REQ   = 1;
    localparam int K_TIMER = 2;
    localparam int K_EPC   = 3;

    logic        clk;
    logic        reset;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        we;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
    logic [31:0] bad_vaddr_in;
    logic        eret;
    logic [5:0]  hw_int;
    logic        int_exc_req;
    logic [31:0] epc;
    logic [31:0] rd_data;
    logic        timer_irq;

    typedef struct {
        string       name;
        int          kind;
        logic [4:0]  addr;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] obs;
    int          total;
    int          bad;

    cp0_timer_irq_unit #(
        .NUM_HWINT (6),
        .EDGE_MASK (6'b000001),
        .TIMER_LINE(5),
        .PRID      (TB_PRID)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .we          (we),
        .pc          (pc),
        .bd          (bd),
        .exc_code    (exc_code),
        .bad_vaddr_in(bad_vaddr_in),
        .eret        (eret),
        .hw_int      (hw_int),
        .int_exc_req (int_exc_req),
        .epc         (epc),
        .rd_data     (rd_data),
        .timer_irq   (timer_irq)
    );

    // Free-running clock, 40 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_REQ:   return {31'd0, int_exc_req};
            K_TIMER: return {31'd0, timer_irq};
            K_EPC:   return epc;
            default: return rd_data;
        endcase
    endfunction

    task automatic pushExp(input string name, input int kind, input logic [4:0] addr,
                           input logic [31:0] val);
        exp_t x;
        x.name = name;
        x.kind = kind;
        x.addr = addr;
        x.val  = val;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        we      = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        we      = 1'b0;
    endtask

    task automatic test_reset();
        pushExp("rst count", K_RD, 5'd9, 32'd0);
        pushExp("rst badvaddr", K_RD, 5'd8, 32'd0);
        pushExp("rst unmapped10", K_RD, 5'd10, 32'd0);
        pushExp("rst compare", K_RD, 5'd11, 32'd0);
        pushExp("rst sr", K_RD, 5'd12, 32'd0);
        pushExp("rst cause", K_RD, 5'd13, 32'd0);
        pushExp("rst epc reg", K_RD, 5'd14, 32'd0);
        pushExp("rst prid", K_RD, 5'd15, TB_PRID);
        pushExp("rst epc out", K_EPC, 5'd0, 32'd0);
        pushExp("rst timer", K_TIMER, 5'd0, 32'd0);
        pushExp("rst req", K_REQ, 5'd0, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        repeat (3) tick();
        pushExp("count after 3", K_RD, 5'd9, 32'd3);
        pushExp("timer count0==compare0", K_TIMER, 5'd0, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        mtc0(5'd11, 32'hFFFF_0000);
        pushExp("compare readback", K_RD, 5'd11, 32'hFFFF_0000);
        pushExp("timer cleared by compare", K_TIMER, 5'd0, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_level_irq();
        pc = 32'h0000_1000;
        mtc0(5'd12, 32'h0000_FC01);
        hw_int = 6'b000100;
        pushExp("sr written", K_RD, 5'd12, 32'h0000_FC01);
        pushExp("req before sample", K_REQ, 5'd0, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
        pushExp("level req raised", K_REQ, 5'd0, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
        hw_int = 6'b000000;
        pushExp("level cause", K_RD, 5'd13, 32'h0000_1000);
        pushExp("level sr exl", K_RD, 5'd12, 32'h0000_FC03);
        pushExp("level epc", K_EPC, 5'd0, 32'h0000_1000);
        pushExp("req masked by exl", K_REQ, 5'd0, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        pushExp("eret sr", K_RD, 5'd12, 32'h0000_FC01);
        pushExp("eret cause", K_RD, 5'd13, 32'h0000_0000);
        pushExp("eret req", K_REQ, 5'd0, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_edge_irq();
        mtc0(5'd12, 32'h0000_0000);
        hw_int = 6'b000001;
        tick();
        hw_int = 6'b000000;
        repeat (2) tick();
        pushExp("edge latched", K_RD, 5'd13, 32'h0000_0400);
        pushExp("edge req ie=0", K_REQ, 5'd0, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        mtc0(5'd13, 32'h0000_0400);
        pushExp("edge kept by bit=1", K_RD, 5'd13, 32'h0000_0400);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        mtc0(5'd13, 32'h0000_0000);
        pushExp("edge cleared", K_RD, 5'd13, 32'h0000_0000);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        hw_int = 6'b000001;
        mtc0(5'd13, 32'h0000_0000);
        hw_int = 6'b000000;
        pushExp("edge set beats clear", K_RD, 5'd13, 32'h0000_0400);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        mtc0(5'd13, 32'h8000_007C);
        pushExp("cause ro fields", K_RD, 5'd13, 32'h0000_0000);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_timer();
        mtc0(5'd9, 32'd15);
        pushExp("count loaded", K_RD, 5'd9, 32'd15);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        mtc0(5'd11, 32'd20);
        pushExp("timer wait 1", K_TIMER, 5'd0, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        for (int i = 2; i <= 6; i++) begin
            tick();
            pushExp($sformatf("timer wait %0d", i), K_TIMER, 5'd0, (i == 6) ? 32'd1 : 32'd0);
            pushExp($sformatf("count wait %0d", i), K_RD, 5'd9, 32'd15 + 32'(i));
            if (i == 6) begin
                pushExp("cause timer ip", K_RD, 5'd13, 32'h0000_8000);
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                rd_addr = e.addr;
                #1;
                obs = observe(e.kind);
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
                end
            end
        end
        repeat (2) tick();
        mtc0(5'd11, 32'd100);
        pushExp("timer cleared", K_TIMER, 5'd0, 32'd0);
        pushExp("cause after clear", K_RD, 5'd13, 32'h0000_0000);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_exception();
        pc           = 32'h0000_3008;
        bd           = 1'b1;
        exc_code     = 5'd5;
        bad_vaddr_in = 32'hDEAD_BEE0;
        pushExp("exc req", K_REQ, 5'd0, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
        exc_code = 5'd0;
        bd       = 1'b0;
        pushExp("exc epc out", K_EPC, 5'd0, 32'h0000_3004);
        pushExp("exc epc reg", K_RD, 5'd14, 32'h0000_3004);
        pushExp("exc cause", K_RD, 5'd13, 32'h8000_0014);
        pushExp("exc badvaddr", K_RD, 5'd8, 32'hDEAD_BEE0);
        pushExp("exc sr", K_RD, 5'd12, 32'h0000_0002);
        pushExp("exc req after", K_REQ, 5'd0, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_back_to_back();
        mtc0(5'd12, 32'h0000_FC01);
        hw_int = 6'b000010;
        tick();
        exc_code     = 5'd4;
        bd           = 1'b0;
        pc           = 32'h0000_4000;
        bad_vaddr_in = 32'h1111_1111;
        we           = 1'b1;
        wr_addr      = 5'd14;
        wr_data      = 32'hCAFE_0000;
        pushExp("int+exc req", K_REQ, 5'd0, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
        we       = 1'b0;
        exc_code = 5'd0;
        hw_int   = 6'b000000;
        pushExp("mtc0 epc dropped", K_EPC, 5'd0, 32'h0000_4000);
        pushExp("int priority cause", K_RD, 5'd13, 32'h0000_0800);
        pushExp("badvaddr unchanged", K_RD, 5'd8, 32'hDEAD_BEE0);
        pushExp("int sr", K_RD, 5'd12, 32'h0000_FC03);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        pushExp("b2b eret sr", K_RD, 5'd12, 32'h0000_FC01);
        pushExp("b2b eret req", K_REQ, 5'd0, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        mtc0(5'd12, 32'h0000_0000);
    endtask

    task automatic test_count_wrap();
        mtc0(5'd9, 32'hFFFF_FFFF);
        pushExp("count max", K_RD, 5'd9, 32'hFFFF_FFFF);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
        pushExp("count wrapped", K_RD, 5'd9, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_reset_busy();
        mtc0(5'd9, 32'd5);
        mtc0(5'd11, 32'd6);
        tick();
        exc_code = 5'd1;
        pc       = 32'h0000_5000;
        pushExp("busy timer set", K_TIMER, 5'd0, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
        exc_code = 5'd0;
        pushExp("busy exl set", K_RD, 5'd12, 32'h0000_0002);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pushExp("rerst sr", K_RD, 5'd12, 32'd0);
        pushExp("rerst cause", K_RD, 5'd13, 32'd0);
        pushExp("rerst epc", K_EPC, 5'd0, 32'd0);
        pushExp("rerst timer", K_TIMER, 5'd0, 32'd0);
        pushExp("rerst count", K_RD, 5'd9, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            obs = observe(e.kind);
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        rd_addr      = 5'd0;
        wr_addr      = 5'd0;
        wr_data      = 32'd0;
        we           = 1'b0;
        pc           = 32'd0;
        bd           = 1'b0;
        exc_code     = 5'd0;
        bad_vaddr_in = 32'd0;
        eret         = 1'b0;
        hw_int       = 6'd0;
        repeat (3) tick();
        reset = 1'b0;
        $display("[TB] starting scenarios");
        test_reset();
        test_level_irq();
        test_edge_irq();
        test_timer();
        test_exception();
        test_back_to_back();
        test_count_wrap();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
